// File: rtl/io_input_capture_if.sv
// CPU-facing read port of io_input_capture: show-ahead capture FIFO plus the sticky overflow flag.
// Handshake: rd_valid is high while the head entry on rd_data is valid; an entry leaves on a rising clk edge where rd_en && rd_valid.
interface io_input_capture_if #(
  parameter int SW_WIDTH   = 16,
  parameter int FIFO_DEPTH = 4
);
  logic                          rd_en;
  logic [SW_WIDTH-1:0]           rd_data;
  logic                          rd_valid;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          overflow;
  logic                          ovf_clear;

  // CPU side
  modport master (
    output rd_en,
    output ovf_clear,
    input  rd_data,
    input  rd_valid,
    input  fifo_count,
    input  overflow
  );

  // capture block side
  modport slave (
    input  rd_en,
    input  ovf_clear,
    output rd_data,
    output rd_valid,
    output fifo_count,
    output overflow
  );
endinterface

// File: rtl/io_input_capture.sv
// Switch/button front-end: 2-flop synchronisers, per-button debounce with press pulses, and a show-ahead
// FIFO of switch snapshots taken on each CAP_BTN press. Optional auto-repeat: IO_INPUT_AUTO_REPEAT_EN.
module io_input_capture #(
  parameter int SW_WIDTH        = 16,
  parameter int BTN_CNT         = 2,
  parameter int CAP_BTN         = 0,
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int CNT_W           = 18,
  parameter int FIFO_DEPTH      = 4,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SW_WIDTH-1:0]  switchInput,
  input  logic [BTN_CNT-1:0]   btn_in,
  output logic [BTN_CNT-1:0]   btn_level,
  output logic [BTN_CNT-1:0]   btn_pulse,
  io_input_capture_if.slave    rd_bus
);

  localparam int                AW       = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW:0]       FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("io_input_capture: DEBOUNCE_CYCLES must be >= 2");
  end
  if ((2 ** CNT_W) <= DEBOUNCE_CYCLES) begin : g_bad_cnt_w
    $error("io_input_capture: CNT_W too narrow for DEBOUNCE_CYCLES");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("io_input_capture: FIFO_DEPTH must be a power of two >= 2");
  end
  if ((CAP_BTN < 0) || (CAP_BTN >= BTN_CNT)) begin : g_bad_cap_btn
    $error("io_input_capture: CAP_BTN out of range");
  end
  if ((REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_bad_repeat
    $error("io_input_capture: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  // ---------------- synchronisers ----------------
  logic [SW_WIDTH-1:0] sw_s1, sw_s2;
  logic [BTN_CNT-1:0]  btn_s1, btn_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= '0;
      btn_s2 <= '0;
    end else begin
      sw_s1  <= switchInput;
      sw_s2  <= sw_s1;
      btn_s1 <= btn_in;
      btn_s2 <= btn_s1;
    end
  end

  // ---------------- debounce ----------------
  logic [CNT_W-1:0]   deb_cnt [BTN_CNT];
  logic [BTN_CNT-1:0] level_q;
  logic [BTN_CNT-1:0] pulse_q;
  logic [BTN_CNT-1:0] accept;
  logic [BTN_CNT-1:0] rise;
  logic [BTN_CNT-1:0] rpt_fire;

  // accept: the mismatch has now persisted for DEBOUNCE_CYCLES consecutive cycles
  always_comb begin
    accept = '0;
    for (int i = 0; i < BTN_CNT; i++) begin
      accept[i] = (btn_s2[i] != level_q[i]) && (deb_cnt[i] == DEB_LAST);
    end
    rise = accept & ~level_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BTN_CNT; i++) deb_cnt[i] <= '0;
      level_q <= '0;
      pulse_q <= '0;
    end else begin
      for (int i = 0; i < BTN_CNT; i++) begin
        if ((btn_s2[i] == level_q[i]) || accept[i]) begin
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
        if (accept[i]) level_q[i] <= btn_s2[i];
      end
      pulse_q <= rise | rpt_fire;
    end
  end

`ifdef IO_INPUT_AUTO_REPEAT_EN
  // ---------------- auto-repeat ----------------
  localparam int             RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int             RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0]   rpt_cnt [BTN_CNT];
  logic [BTN_CNT-1:0] rpt_first;
  logic [BTN_CNT-1:0] fall;

  // rpt_cnt holds the cycles elapsed since the last pulse on a channel that is held down
  always_comb begin
    fall     = accept & level_q;
    rpt_fire = '0;
    for (int i = 0; i < BTN_CNT; i++) begin
      rpt_fire[i] = level_q[i] && !fall[i] &&
                    (rpt_first[i] ? (rpt_cnt[i] == RPT_DELAY_LAST)
                                  : (rpt_cnt[i] == RPT_PERIOD_LAST));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BTN_CNT; i++) rpt_cnt[i] <= '0;
      rpt_first <= '1;
    end else begin
      for (int i = 0; i < BTN_CNT; i++) begin
        if (!level_q[i] || fall[i]) begin
          rpt_cnt[i]   <= '0;
          rpt_first[i] <= 1'b1;
        end else if (rpt_fire[i]) begin
          rpt_cnt[i]   <= '0;
          rpt_first[i] <= 1'b0;
        end else begin
          rpt_cnt[i]   <= rpt_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign rpt_fire = '0;
`endif

  assign btn_level = level_q;
  assign btn_pulse = pulse_q;

  // ---------------- capture FIFO ----------------
  logic [SW_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count;
  logic                push_req, push, pop, full, drop;

  always_comb begin
    push_req = pulse_q[CAP_BTN];
    full     = (count == FULL_CNT);
    pop      = rd_bus.rd_en && (count != '0);
    // a full FIFO still accepts a push when the head leaves on the same edge
    push     = push_req && (!full || pop);
    drop     = push_req && full && !pop;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sw_s2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  logic overflow_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (rd_bus.ovf_clear) begin
      overflow_q <= 1'b0;
    end
  end

  assign rd_bus.rd_valid   = (count != '0);
  assign rd_bus.rd_data    = (count != '0) ? mem[rd_ptr] : '0;
  assign rd_bus.fifo_count = count;
  assign rd_bus.overflow   = overflow_q;

endmodule

// File: tb/tb_io_input_capture.sv
// Bench for io_input_capture: directed scenarios with literal expectations plus randomized stimulus
// compared every cycle against a queue/window based reference model.
module tb_io_input_capture;
  localparam int SW_WIDTH   = 16;
  localparam int BTN_CNT    = 2;
  localparam int CAP_BTN    = 0;
  localparam int DEB        = 4;
  localparam int CNT_W      = 3;
  localparam int DEPTH      = 4;
  localparam int RPT_DELAY  = 10;
  localparam int RPT_PERIOD = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [SW_WIDTH-1:0] sw  = '0;
  logic [BTN_CNT-1:0]  btn = '0;
  logic [BTN_CNT-1:0]  btn_level, btn_pulse;

  io_input_capture_if #(.SW_WIDTH(SW_WIDTH), .FIFO_DEPTH(DEPTH)) bus ();

  io_input_capture #(
    .SW_WIDTH(SW_WIDTH), .BTN_CNT(BTN_CNT), .CAP_BTN(CAP_BTN),
    .DEBOUNCE_CYCLES(DEB), .CNT_W(CNT_W), .FIFO_DEPTH(DEPTH),
    .REPEAT_DELAY(RPT_DELAY), .REPEAT_PERIOD(RPT_PERIOD)
  ) dut (
    .clk(clk), .reset(reset), .switchInput(sw), .btn_in(btn),
    .btn_level(btn_level), .btn_pulse(btn_pulse), .rd_bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [BTN_CNT-1:0]  m_d1, m_d2;
  logic [SW_WIDTH-1:0] m_sw1, m_sw2;
  logic [DEB-1:0]      m_hist [BTN_CNT];
  int                  m_hist_n [BTN_CNT];
  logic [BTN_CNT-1:0]  m_level, m_pulse;
  logic [SW_WIDTH-1:0] exp_q[$];
  logic                m_ovf;
  int                  m_since [BTN_CNT];
  bit                  m_first [BTN_CNT];
  bit                  model_live = 1'b0;

  always @(posedge clk) begin : model_p
    logic [BTN_CNT-1:0]  seen_btn, new_pulse;
    logic [SW_WIDTH-1:0] seen_sw;
    bit pop, push, drop;
    if (reset) begin
      m_d1 = '0; m_d2 = '0; m_sw1 = '0; m_sw2 = '0;
      m_level = '0; m_pulse = '0; m_ovf = 1'b0;
      exp_q.delete();
      for (int i = 0; i < BTN_CNT; i++) begin
        m_hist[i] = '0; m_hist_n[i] = 0; m_since[i] = 0; m_first[i] = 1'b1;
      end
      model_live = 1'b1;
    end else begin
      // what the logic sees this edge is the raw value from two edges back
      seen_btn = m_d2; seen_sw = m_sw2;
      m_d2 = m_d1; m_d1 = btn; m_sw2 = m_sw1; m_sw1 = sw;

      pop  = bus.rd_en && (exp_q.size() > 0);
      push = m_pulse[CAP_BTN];
      drop = push && (exp_q.size() == DEPTH) && !pop;
      if (pop) void'(exp_q.pop_front());
      if (push && !drop) exp_q.push_back(seen_sw);
      if (drop) m_ovf = 1'b1;
      else if (bus.ovf_clear) m_ovf = 1'b0;

      new_pulse = '0;
      for (int i = 0; i < BTN_CNT; i++) begin
        m_hist[i] = {m_hist[i][DEB-2:0], seen_btn[i]};
        if (m_hist_n[i] < DEB) m_hist_n[i]++;
        if ((m_hist_n[i] == DEB) && (m_hist[i] == {DEB{~m_level[i]}})) begin
          m_level[i] = ~m_level[i];
          if (m_level[i]) begin
            new_pulse[i] = 1'b1; m_since[i] = 0; m_first[i] = 1'b1;
          end
        end else if (m_level[i]) begin
`ifdef IO_INPUT_AUTO_REPEAT_EN
          m_since[i]++;
          if (m_since[i] == (m_first[i] ? RPT_DELAY : RPT_PERIOD)) begin
            new_pulse[i] = 1'b1; m_since[i] = 0; m_first[i] = 1'b0;
          end
`endif
        end
      end
      m_pulse = new_pulse;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (model_live) begin
      check("btn_level", btn_level, m_level);
      check("btn_pulse", btn_pulse, m_pulse);
      check("rd_valid", bus.rd_valid, exp_q.size() > 0);
      check("fifo_count", bus.fifo_count, exp_q.size());
      check("overflow", bus.overflow, m_ovf);
      if (exp_q.size() > 0) check("rd_data", bus.rd_data, exp_q[0]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    btn = '0; reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
  endtask

  task automatic press(input int idx, input logic [SW_WIDTH-1:0] val);
    sw = val; btn[idx] = 1'b1;
    tick(9);
    btn[idx] = 1'b0;
    tick(9);
  endtask

  task automatic pop_one();
    bus.rd_en = 1'b1;
    tick(1);
    bus.rd_en = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin : main_p
    int rise_k, hi_cnt, pulse_cnt;
    bit found;
    logic [63:0] mask;
    bus.rd_en = 1'b0; bus.ovf_clear = 1'b0;

    // reset with button 0 held
    btn = 2'b01; reset = 1'b1;
    tick(2);
    check("rst_level", btn_level, 0);
    check("rst_pulse", btn_pulse, 0);
    check("rst_count", bus.fifo_count, 0);
    check("rst_valid", bus.rd_valid, 0);
    check("rst_ovf", bus.overflow, 0);
    reset = 1'b0;
    rise_k = 0;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (btn_level[0] && rise_k == 0) rise_k = k;
    end
    check("rst_rise_latency", rise_k, 6);
    btn = '0; tick(10);
    do_reset();

    // 3-cycle glitch, then a clean press
    btn[0] = 1'b1; tick(3); btn[0] = 1'b0;
    hi_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      if (btn_level[0] || btn_pulse[0]) hi_cnt++;
    end
    check("glitch_ignored", hi_cnt, 0);
    btn[0] = 1'b1;
    rise_k = 0; pulse_cnt = 0;
    for (int k = 1; k <= 15; k++) begin
      tick(1);
      if (btn_level[0] && rise_k == 0) rise_k = k;
      if (btn_pulse[0]) pulse_cnt++;
    end
    check("press_latency", rise_k, 6);
    check("press_pulse_width", pulse_cnt, 1);
    btn = '0; tick(10);
    do_reset();

    // capture and read
    press(0, 16'h0001);
    check("cap1_valid", bus.rd_valid, 1);
    check("cap1_data", bus.rd_data, 16'h0001);
    check("cap1_count", bus.fifo_count, 1);
    press(0, 16'h0003);
    check("cap2_count", bus.fifo_count, 2);
    pop_one();
    check("pop1_data", bus.rd_data, 16'h0003);
    check("pop1_count", bus.fifo_count, 1);
    pop_one();
    pop_one();
    check("empty_count", bus.fifo_count, 0);
    check("empty_valid", bus.rd_valid, 0);

    // overflow
    for (int i = 0; i < 5; i++) press(0, 16'hA000 + 16'(i));
    check("ovf_count", bus.fifo_count, 4);
    check("ovf_set", bus.overflow, 1);
    for (int i = 0; i < 4; i++) begin
      check("ovf_pop_data", bus.rd_data, 16'hA000 + 16'(i));
      pop_one();
    end
    check("ovf_drained", bus.fifo_count, 0);
    bus.ovf_clear = 1'b1; tick(1); bus.ovf_clear = 1'b0;
    check("ovf_cleared", bus.overflow, 0);

    // full FIFO: push and pop on the same edge
    for (int i = 0; i < 4; i++) press(0, 16'hB000 + 16'(i));
    check("full_count", bus.fifo_count, 4);
    sw = 16'hB004; btn[0] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick(1);
      if (btn_pulse[0]) found = 1'b1;
    end
    check("full_pp_pulse_seen", found, 1);
    bus.rd_en = 1'b1; tick(1); bus.rd_en = 1'b0; btn = '0;
    check("full_pp_count", bus.fifo_count, 4);
    check("full_pp_ovf", bus.overflow, 0);
    tick(9);
    for (int i = 0; i < 4; i++) begin
      check("full_pp_order", bus.rd_data, 16'hB001 + 16'(i));
      pop_one();
    end

`ifdef IO_INPUT_AUTO_REPEAT_EN
    // auto-repeat on button 1, released so the level drops between +25 and +30
    do_reset();
    btn[1] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick(1);
      if (btn_pulse[1]) found = 1'b1;
    end
    check("rpt_first_pulse", found, 1);
    mask = '0;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      if (btn_pulse[1]) mask[k] = 1'b1;
      if (k == 22) btn[1] = 1'b0;
    end
    check("rpt_pulse_mask", mask, (64'd1 << 10) | (64'd1 << 15) | (64'd1 << 20) | (64'd1 << 25));
`else
    mask = '0;
`endif

    // randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) btn = BTN_CNT'($urandom_range(0, (1 << BTN_CNT) - 1));
      sw = SW_WIDTH'($urandom);
      bus.rd_en = ($urandom_range(0, 3) == 0);
      bus.ovf_clear = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 599) == 0);
      tick(1);
    end
    reset = 1'b0; bus.rd_en = 1'b0; bus.ovf_clear = 1'b0; btn = '0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog_p
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/io_input_capture.md
Name: io_input_capture

Overview:
- Parametrised front-end for the board's switches and push-buttons. It feeds the CPU's memory-mapped input port.
- Synchronises and debounces BTN_CNT buttons and emits single-cycle press pulses.
- On each press of the capture button, snapshots the switch bank into a small show-ahead FIFO, which the CPU drains with a read strobe.
- Replaces direct sampling of the raw switch and enter lines.

Parameters:
- SW_WIDTH, 16, width of the switch bank
- BTN_CNT, 2, number of button channels
- CAP_BTN, 0, index of the button whose press captures the switches
- DEBOUNCE_CYCLES, 200000, stable cycles required to accept a new button level (must be >= 2)
- CNT_W, 18, debounce counter width (must satisfy 2^CNT_W > DEBOUNCE_CYCLES)
- FIFO_DEPTH, 4, capture FIFO entries (power of two, >= 2)
- REPEAT_DELAY, 50000000, auto-repeat first delay in cycles (macro only)
- REPEAT_PERIOD, 10000000, auto-repeat period in cycles (macro only)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous reset, active-high
- switchInput  in  SW_WIDTH  raw asynchronous switches
- btn_in  in  BTN_CNT  raw asynchronous buttons, 1 = pressed
- btn_level  out  BTN_CNT  debounced button level
- btn_pulse  out  BTN_CNT  one-cycle pulse on each accepted press
- rd_en  in  1  pop strobe from the CPU
- rd_data  out  SW_WIDTH  head FIFO entry (show-ahead)
- rd_valid  out  1  FIFO not empty
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of occupied entries
- overflow  out  1  sticky: a capture was dropped
- ovf_clear  in  1  clears overflow

Behaviour:
- Clock and reset: single clock domain, clk. reset is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values:
  - btn_level, btn_pulse, fifo_count, rd_valid and overflow are all 0.
  - rd_data is 0.
  - Synchroniser and debounce counters are cleared.
  - FIFO pointers are 0.
  - Reset mid-operation discards all FIFO contents and any partial debounce.
- Synchronisers: two flip-flop stages on every switchInput and btn_in bit. Captured data always comes from the second stage.
- Debounce (per channel):
  - When sync != btn_level, the counter increments.
  - When sync == btn_level, the counter clears.
  - When the counter reaches DEBOUNCE_CYCLES-1 with a mismatch still present, btn_level takes the sync value and the counter clears.
  - Total latency from a clean raw edge to the btn_level change is 2 + DEBOUNCE_CYCLES cycles.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes btn_level.
- btn_pulse[i] is high for exactly the one cycle in which btn_level[i] goes 0->1. Release produces no pulse.
- Capture:
  - On a cycle with btn_pulse[CAP_BTN]=1, the current synchronised switch word is pushed at that clock edge.
  - rd_valid and fifo_count reflect the push on the following cycle.
- Pop:
  - rd_en=1 with rd_valid=1 advances the head at the clock edge.
  - rd_en with the FIFO empty is ignored; no pointer change.
  - rd_data shows the head entry combinationally from storage.
  - rd_data value is don't-care when empty; the bench must not check it.
- Full FIFO:
  - A push with no simultaneous pop is dropped; contents are unchanged and overflow is set to 1.
  - A push with a simultaneous pop both succeed; count stays FIFO_DEPTH and overflow stays unchanged.
- Simultaneous push and pop on a non-empty, non-full FIFO: count unchanged, and data order is preserved.
- Pointers wrap modulo FIFO_DEPTH. The count distinguishes full from empty.
- overflow clears on ovf_clear. If a drop occurs in the same cycle as ovf_clear, the set wins.

Optional Feature:
- Macro: IO_INPUT_AUTO_REPEAT_EN
- Defined:
  - While btn_level[i] stays 1, a per-channel timer runs.
  - An extra btn_pulse[i] is issued REPEAT_DELAY cycles after the initial pulse, then every REPEAT_PERIOD cycles.
  - Releasing the button stops and clears the timer.
  - Repeat pulses on CAP_BTN also capture.
- Undefined: the timers are absent and exactly one pulse is issued per press.

Test Plan (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4, SW_WIDTH=16):
- Reset: assert reset for 2 cycles while btn_in=1 -> all outputs 0; btn_level rises 6 cycles after reset deasserts.
- Glitch: btn_in[0] high for 3 cycles -> btn_level and btn_pulse stay 0. Then hold it high -> btn_level=1 at 2+4 cycles after the edge, and btn_pulse[0] is high for exactly 1 cycle.
- Capture/read: switchInput=16'h0001, press btn0 -> rd_valid=1, rd_data=16'h0001, fifo_count=1. Change to 16'h0003, press again -> fifo_count=2. Pulse rd_en -> rd_data=16'h0003, fifo_count=1. Pulse rd_en twice -> empty, and the second pop has no effect.
- Overflow: perform 5 captures of 16'hA000..16'hA004 with no reads -> fifo_count=4, overflow=1, and pops return A000, A001, A002, A003. Then ovf_clear -> overflow=0.
- Full push+pop: with a full FIFO, press btn0 in the same cycle as rd_en -> fifo_count stays 4, overflow stays 0, and the newest entry is at the tail.
- Auto-repeat (macro defined, REPEAT_DELAY=10, REPEAT_PERIOD=5): hold btn1 for 30 cycles after acceptance -> pulses at +0, +10, +15, +20 and +25; releasing stops further pulses.
